// File: rtl/stream_to_sync_out.sv
// Pixel stream sink: show-ahead FIFO replayed against a free-running raster generator.
// Optional colour-bar override when STREAM_TO_SYNC_PATTERN_EN is defined (adds pattern_i).
module stream_to_sync_out #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 1024,
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter int SYNC_POL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_r_i,
  input  logic [DATA_WIDTH-1:0] data_g_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  input  logic                  valid_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
`ifdef STREAM_TO_SYNC_PATTERN_EN
  input  logic                  pattern_i,
`endif
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_r_o,
  output logic [DATA_WIDTH-1:0] data_g_o,
  output logic [DATA_WIDTH-1:0] data_b_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic                  locked_o,
  output logic                  underflow_o,
  output logic                  sync_err_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = 3 * DATA_WIDTH;
  localparam int FW = CW + 2;
  localparam logic POL = (SYNC_POL != 0);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {HUNT, PRIME, RUN} state_t;
  state_t state, state_nxt;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic h_last, v_last, active, hs_act, vs_act, first_px, last_px;

  assign h_last   = (h_cnt == H_LAST);
  assign v_last   = (v_cnt == V_LAST);
  assign active   = (h_cnt <= H_ACT_LAST) && (v_cnt <= V_ACT_LAST);
  assign hs_act   = (h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END);
  assign vs_act   = (v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END);
  assign first_px = (h_cnt == '0) && (v_cnt == '0);
  assign last_px  = (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);

  // Raster counters free-run regardless of lock state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + HW'(1);
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end
  end

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] head;
  logic [AW-1:0] waddr;
  logic empty, full, head_sop, head_eop;
  logic pop_slot, underflow, misalign, rd_en, wr_en, flush, accept;

  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_sop = head[1];
  assign head_eop = head[0];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign ready_o  = !full && !reset;
  assign waddr    = flush ? '0 : wr_ptr[AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      HUNT:    if (wr_en) state_nxt = PRIME;
      PRIME:   if (h_last && v_last) state_nxt = RUN;
      RUN:     if (underflow || misalign) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // Errors are judged on the slot being popped; an empty slot counts as underflow only.
  always_comb begin
    pop_slot  = (state == RUN) && active;
    underflow = pop_slot && empty;
    misalign  = pop_slot && !empty && ((head_sop != first_px) || (head_eop != last_px));
    rd_en     = pop_slot && !empty;
    flush     = (state == HUNT) || underflow || misalign;
    accept    = valid_i && ready_o;
    wr_en     = accept && ((state == HUNT) ? sop_i : !(underflow || misalign));
  end

  // A flush restarts the pointers, keeping a sop word that lands in the same clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= PW'(wr_en);
    end else begin
      rd_ptr <= rd_ptr + PW'(rd_en);
      wr_ptr <= wr_ptr + PW'(wr_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= {data_r_i, data_g_i, data_b_i, sop_i, eop_i};
  end

  logic [CW-1:0] rgb_d;
`ifdef STREAM_TO_SYNC_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [31:0] bar;
  logic [2:0]  bar_idx;
  assign bar     = 32'(h_cnt) / 32'(BAR_W);
  assign bar_idx = (bar > 32'd7) ? 3'd7 : bar[2:0];
`endif

  always_comb begin
    rgb_d = (rd_en && !misalign) ? head[FW-1:2] : '0;
`ifdef STREAM_TO_SYNC_PATTERN_EN
    // Bar order white..black maps to complemented index bits per channel.
    if (pattern_i && active)
      rgb_d = {{DATA_WIDTH{!bar_idx[1]}}, {DATA_WIDTH{!bar_idx[2]}}, {DATA_WIDTH{!bar_idx[0]}}};
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_o        <= 1'b0;
      hsync_o     <= !POL;
      vsync_o     <= !POL;
      data_r_o    <= '0;
      data_g_o    <= '0;
      data_b_o    <= '0;
      locked_o    <= 1'b0;
      underflow_o <= 1'b0;
      sync_err_o  <= 1'b0;
    end else begin
      de_o        <= active;
      hsync_o     <= hs_act ^ !POL;
      vsync_o     <= vs_act ^ !POL;
      {data_r_o, data_g_o, data_b_o} <= rgb_d;
      locked_o    <= (state_nxt == RUN);
      underflow_o <= underflow;
      sync_err_o  <= misalign;
    end
  end
endmodule

// File: doc/stream_to_sync_out.md
Name: stream_to_sync_out

Overview:
- Sink end of the RGB valid/sop/eop pixel stream produced by the conv-filter chain.
- Buffers the stream in a show-ahead FIFO and replays it against a free-running raster timing generator as hsync/vsync/de + RGB for the display PHY.
- Locks to stream frame boundaries, detects underflow and sop/eop misalignment, and re-locks on the next frame.

Parameters:
DATA_WIDTH, 8, bits per colour channel
FIFO_DEPTH, 1024, FIFO words, power of two, >= 4
H_ACTIVE, 1920, active pixels per line
H_FP, 88, horizontal front porch, clocks
H_SYNC, 44, hsync width, clocks
H_BP, 148, horizontal back porch, clocks
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch, lines
V_SYNC, 5, vsync width, lines
V_BP, 36, vertical back porch, lines
SYNC_POL, 1, 1 = sync pulses active-high, 0 = active-low

Ports:
clk  in  1  pixel clock, sole clock
reset  in  1  asynchronous, active-high reset
data_r_i / data_g_i / data_b_i  in  DATA_WIDTH each  stream pixel
valid_i  in  1  pixel qualifier
sop_i  in  1  first pixel of frame, with valid_i
eop_i  in  1  last pixel of frame, with valid_i
ready_o  out  1  backpressure; a word transfers when valid_i & ready_o
data_r_o / data_g_o / data_b_o  out  DATA_WIDTH each  output pixel, 0 outside de_o
hsync_o / vsync_o / de_o  out  1 each  raster timing
locked_o  out  1  high while in RUN
underflow_o  out  1  one-clock pulse on underflow
sync_err_o  out  1  one-clock pulse on sop/eop misalignment

Behaviour:
- Reset: all outputs 0 except hsync_o and vsync_o, which are at the inactive level (!SYNC_POL). Counters are 0, FIFO is empty, state is HUNT.
- Timing generator:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt wraps at H_TOTAL-1; v_cnt increments on h wrap and wraps at V_TOTAL-1. It free-runs in every state.
  - Active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hsync active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync active for v_cnt in the equivalent range, changing at h_cnt==0.
  - All outputs are registered: 1 clock from counter value to pins.
- FIFO: width 3*DATA_WIDTH+2 (rgb, sop, eop), show-ahead.
  - ready_o = !full in HUNT/PRIME/RUN. Writes are gated by state.
  - Simultaneous read and write when full is allowed only if the read precedes the write in the same clock; ready_o stays !full (conservative).
- State machine:
  - HUNT: FIFO held cleared. ready_o=1, non-sop words discarded. A valid&sop word is written; go to PRIME.
  - PRIME: all accepted words are written. At h_cnt==H_TOTAL-1 & v_cnt==V_TOTAL-1, go to RUN, so pixel (0,0) is the first RUN pixel.
  - RUN: on each active clock, pop one word and drive it on the RGB outputs with de_o=1. Errors are checked on the popped slot:
    - FIFO empty -> underflow_o pulse; output black.
    - pixel (0,0) without sop, sop on any other pixel, eop absent at (H_ACTIVE-1, V_ACTIVE-1), or eop elsewhere -> sync_err_o pulse.
    - On either error: flush FIFO, go to HUNT. de_o/hsync/vsync keep running; RGB is 0 until re-lock.
  - Underflow and misalignment in the same clock: underflow_o only.
- Outside RUN: de_o still follows timing, RGB=0, locked_o=0.
- sop and eop on the same word (1-pixel frame) is treated as a misalignment unless H_ACTIVE*V_ACTIVE==1.
- Reset mid-frame: immediate return to reset values; no partial frame is output afterwards.

Optional Feature:
- Macro STREAM_TO_SYNC_PATTERN_EN.
- When defined: adds input pattern_i (1 bit). While pattern_i=1, RGB outputs show 8 vertical colour bars of width H_ACTIVE/8: white, yellow, cyan, green, magenta, red, blue, black, with channels full-scale or 0. The FIFO and state machine keep running and are unaffected, and locked_o is unchanged.
- When undefined: no pattern_i port and no pattern logic.

Test Plan:
- H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, SYNC_POL=1, no stream -> de_o high 4 of every 8 clocks on lines 0-1, hsync_o high at h_cnt 5-6, vsync_o high on line 3, RGB=0, locked_o=0.
- Same params, continuous frames of 8 pixels with values 1..8, sop on 1, eop on 8 -> locked_o rises at the frame wrap; de_o cycles output 1,2,3,4 then 5,6,7,8; no error pulses.
- Stream stalls for 20 clocks mid-frame after lock -> underflow_o single pulse, RGB=0, locked_o=0; re-lock and correct pixels at the next frame after a fresh sop.
- Frame of 7 pixels (eop on pixel 7) -> sync_err_o pulse at the 7th output pixel; FIFO flushed; re-lock on the following good frame.
- FIFO_DEPTH=4, frames sent at full rate before lock -> ready_o drops when 4 words are buffered; no word lost or duplicated after lock.
- reset asserted mid-active-line -> within the same clock, outputs are 0, syncs inactive, locked_o=0; after release, HUNT discards non-sop words.
